// File: rtl/hazard_forward_ctrl.sv
// Decode-stage hazard/forwarding controller: registered EX operand selects, load-use bubble, mul/div hold.
// Optional FWD_PERF_CNT_EN adds saturating load-use and mul/div stall-cycle counters.
package pipes;
  typedef enum logic [1:0] {
    FROM_ID_EX_ID = 2'd0,
    FROM_ALU_OUT  = 2'd1,
    FROM_WB       = 2'd2
  } forwarding_control;
endpackage

module hazard_forward_ctrl
  import pipes::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_regwrite,
  input  logic                  ex_is_load,
  input  logic                  ex_muldiv,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  dmem_stall,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_ex,
  output logic                  flush_mem,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]           lu_stall_cnt,
  output logic [31:0]           md_stall_cnt,
`endif
  output forwarding_control     fwd_rs1,
  output forwarding_control     fwd_rs2
);

  // state   | meaning
  // RUN     | normal issue, load-use detection active
  // MD_BUSY | mul/div resident in EX, cnt counts elapsed EX cycles
  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [3:0] CNT_LAST   = 4'(MULDIV_LAT - 1);
  localparam bit         MD_STALLS  = (MULDIV_LAT > 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  forwarding_control fwd_rs1_q, fwd_rs1_d;
  forwarding_control fwd_rs2_q, fwd_rs2_d;

  logic hit_e_rs1, hit_e_rs2, hit_m_rs1, hit_m_rs2;
  logic md_entry, md_active, lu;
  forwarding_control sel_rs1, sel_rs2;

  function automatic logic hit(input logic v, input logic wr, input logic [REG_ADDR_W-1:0] rd,
                               input logic use_src, input logic [REG_ADDR_W-1:0] rs);
    return v & wr & (rd != '0) & use_src & (rs == rd);
  endfunction

  function automatic forwarding_control pick(input logic he, input logic hm);
    if (he && !ex_is_load) return FROM_ALU_OUT;
    else if (hm)           return FROM_WB;
    else                   return FROM_ID_EX_ID;
  endfunction

  always_comb begin
    hit_e_rs1 = hit(ex_valid, ex_regwrite, ex_rd, id_use_rs1, id_rs1);
    hit_e_rs2 = hit(ex_valid, ex_regwrite, ex_rd, id_use_rs2, id_rs2);
    hit_m_rs1 = hit(mem_valid, mem_regwrite, mem_rd, id_use_rs1, id_rs1);
    hit_m_rs2 = hit(mem_valid, mem_regwrite, mem_rd, id_use_rs2, id_rs2);
    sel_rs1   = pick(hit_e_rs1, hit_m_rs1);
    sel_rs2   = pick(hit_e_rs2, hit_m_rs2);
    md_entry  = MD_STALLS && (state_q == RUN) && ex_valid && ex_muldiv;
    md_active = md_entry || ((state_q == MD_BUSY) && (cnt_q < CNT_LAST));
    lu        = id_valid && (state_q == RUN) && ex_is_load && (hit_e_rs1 || hit_e_rs2) && !md_active;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      fwd_rs1_q <= FROM_ID_EX_ID;
      fwd_rs2_q <= FROM_ID_EX_ID;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  // Next state; a memory stall freezes everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;
    if (!dmem_stall) begin
      case (state_q)
        RUN: if (md_entry) begin
          state_d = MD_BUSY;
          cnt_d   = 4'd1;
        end
        MD_BUSY: if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
      if (!md_active) begin
        if (lu || !id_valid) begin
          fwd_rs1_d = FROM_ID_EX_ID;
          fwd_rs2_d = FROM_ID_EX_ID;
        end else begin
          fwd_rs1_d = sel_rs1;
          fwd_rs2_d = sel_rs2;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    if (reset) begin
      if (dmem_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else begin
        stall_if  = md_active || lu;
        stall_id  = md_active || lu;
        stall_ex  = md_active;
        flush_ex  = lu;
        flush_mem = md_active;
      end
    end
  end

  assign fwd_rs1 = fwd_rs1_q;
  assign fwd_rs2 = fwd_rs2_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, lu_cnt_d, md_cnt_q, md_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    md_cnt_d = md_cnt_q;
    if (!dmem_stall && lu && (lu_cnt_q != 32'hFFFF_FFFF))        lu_cnt_d = lu_cnt_q + 32'd1;
    if (!dmem_stall && md_active && (md_cnt_q != 32'hFFFF_FFFF)) md_cnt_d = md_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign md_stall_cnt = md_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl; a negedge monitor pops expected controls from a queue.
module tb_hazard_forward_ctrl;
  import pipes::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       ex_valid, ex_regwrite, ex_is_load, ex_muldiv;
  logic       mem_valid, mem_regwrite, dmem_stall;
  logic       stall_if, stall_id, stall_ex, flush_ex, flush_mem;
  forwarding_control fwd_rs1, fwd_rs2;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, md_stall_cnt;
`endif

  hazard_forward_ctrl #(.MULDIV_LAT(4), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_muldiv(ex_muldiv), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .dmem_stall(dmem_stall),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .flush_mem(flush_mem),
`ifdef FWD_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
  );

  // ctl = {stall_if, stall_id, stall_ex, flush_ex, flush_mem}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_MD   = 5'b11101;
  localparam logic [4:0] C_DMEM = 5'b11100;

  typedef struct {
    string             name;
    logic [4:0]        ctl;
    forwarding_control f1;
    forwarding_control f2;
    bit                chk_cnt;
    int unsigned       lu;
    int unsigned       md;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string n, input logic [4:0] c, input forwarding_control a,
                      input forwarding_control b, input bit cc = 1'b0,
                      input int unsigned l = 0, input int unsigned m = 0);
    exp_t e;
    e.name = n; e.ctl = c; e.f1 = a; e.f2 = b; e.chk_cnt = cc; e.lu = l; e.md = m;
    q.push_back(e);
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_muldiv = 0; ex_rd = 0;
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0; dmem_stall = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_alu(input logic [4:0] rd);
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 0; ex_rd = rd;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rd = rd;
  endtask

  task automatic mem_wr(input logic [4:0] rd);
    mem_valid = 1; mem_regwrite = 1; mem_rd = rd;
  endtask

  task automatic id_src(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
    id_valid = 1; id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {stall_if, stall_id, stall_ex, flush_ex, flush_mem};
      n_cmp++;
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
      end
      n_cmp++;
      if (fwd_rs1 !== e.f1) begin
        n_bad++;
        $display("FAIL %s fwd_rs1: got %0d want %0d", e.name, fwd_rs1, e.f1);
      end
      n_cmp++;
      if (fwd_rs2 !== e.f2) begin
        n_bad++;
        $display("FAIL %s fwd_rs2: got %0d want %0d", e.name, fwd_rs2, e.f2);
      end
`ifdef FWD_PERF_CNT_EN
      if (e.chk_cnt) begin
        n_cmp++;
        if (lu_stall_cnt !== e.lu) begin
          n_bad++;
          $display("FAIL %s lu_stall_cnt: got %0d want %0d", e.name, lu_stall_cnt, e.lu);
        end
        n_cmp++;
        if (md_stall_cnt !== e.md) begin
          n_bad++;
          $display("FAIL %s md_stall_cnt: got %0d want %0d", e.name, md_stall_cnt, e.md);
        end
      end
`endif
    end
  end

  initial begin
    reset = 0;
    idle();
    repeat (2) @(posedge clk);

    // Reset holds outputs low even with a mul/div in EX
    cyc(); reset = 0; idle(); ex_valid = 1; ex_muldiv = 1;
    push("rst_hold", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); reset = 1; idle();
    push("rst_out", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);

    // ALU producer rd=5 -> rs1
    cyc(); idle(); ex_alu(5); id_src(1, 5, 1, 6);
    push("alu_issue", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle();
    push("alu_fwd", C_NONE, FROM_ALU_OUT, FROM_ID_EX_ID);

    // Load-use on rs2=7
    cyc(); idle(); ex_load(7); id_src(1, 1, 1, 7);
    push("lu_stall", C_LU, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle(); mem_wr(7); id_src(1, 1, 1, 7);
    push("lu_bubble", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle();
    push("lu_wb", C_NONE, FROM_ID_EX_ID, FROM_WB);

    // EX beats MEM on the same register; x0 never forwards
    cyc(); idle(); ex_alu(3); mem_wr(3); id_src(1, 3, 0, 0);
    push("prio_issue", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle(); ex_alu(0); mem_wr(0); id_src(1, 0, 1, 0);
    push("prio_alu", C_NONE, FROM_ALU_OUT, FROM_ID_EX_ID);
    cyc(); idle();
    push("x0_none", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);

    // Both operands on a load: one bubble only
    cyc(); idle(); ex_load(9); id_src(1, 9, 1, 9);
    push("lu2_stall", C_LU, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle(); mem_wr(9); id_src(1, 9, 1, 9);
    push("lu2_bubble", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle();
    push("lu2_wb", C_NONE, FROM_WB, FROM_WB);

    // Mul/div, 3 stalled cycles, select held throughout
    cyc(); idle(); ex_alu(5); id_src(1, 5, 0, 0);
    push("md_pre", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle(); ex_alu(8); ex_muldiv = 1; id_src(0, 0, 1, 8);
    push("md_c0", C_MD, FROM_ALU_OUT, FROM_ID_EX_ID);
    cyc(); push("md_c1", C_MD, FROM_ALU_OUT, FROM_ID_EX_ID);
    cyc(); push("md_c2", C_MD, FROM_ALU_OUT, FROM_ID_EX_ID);
    cyc(); push("md_c3", C_NONE, FROM_ALU_OUT, FROM_ID_EX_ID);
    cyc(); idle();
    push("md_done", C_NONE, FROM_ID_EX_ID, FROM_ALU_OUT, 1'b1, 2, 3);

    // dmem_stall freezes MD_BUSY at cnt=2
    cyc(); idle(); ex_alu(4); ex_muldiv = 1; id_src(1, 4, 0, 0);
    push("dm_c0", C_MD, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); push("dm_c1", C_MD, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); dmem_stall = 1; push("dm_frz1", C_DMEM, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); push("dm_frz2", C_DMEM, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); dmem_stall = 0; push("dm_c2", C_MD, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); push("dm_c3", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); idle();
    push("dm_done", C_NONE, FROM_ALU_OUT, FROM_ID_EX_ID, 1'b1, 2, 6);

    // dmem_stall overrides a load-use
    cyc(); idle(); ex_load(7); id_src(0, 0, 1, 7); dmem_stall = 1;
    push("lu_dmem", C_DMEM, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); dmem_stall = 0;
    push("lu_after", C_LU, FROM_ID_EX_ID, FROM_ID_EX_ID);

    // Reset in the middle of MD_BUSY
    cyc(); idle(); ex_alu(5); id_src(1, 5, 1, 5);
    push("rx_pre", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID, 1'b1, 3, 6);
    cyc(); idle(); ex_valid = 1; ex_muldiv = 1;
    push("rx_c0", C_MD, FROM_ALU_OUT, FROM_ALU_OUT);
    cyc(); reset = 0;
    push("rx_rst", C_NONE, FROM_ALU_OUT, FROM_ALU_OUT);
    cyc(); reset = 1; idle();
    push("rx_clear", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID, 1'b1, 0, 0);
    cyc(); ex_valid = 1; ex_muldiv = 1;
    push("rx_m0", C_MD, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); push("rx_m1", C_MD, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); push("rx_m2", C_MD, FROM_ID_EX_ID, FROM_ID_EX_ID);
    cyc(); push("rx_m3", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID, 1'b1, 0, 3);
    cyc(); idle();
    push("rx_end", C_NONE, FROM_ID_EX_ID, FROM_ID_EX_ID);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Decode-stage hazard and forwarding controller. It generates the per-operand forwarding select consumed by the EX-stage rd forwarding muxes, plus the pipeline stall and bubble controls.
- It compares ID-stage sources against EX and MEM destinations and registers the selects so they are valid when the instruction enters EX.
- It inserts a one-cycle bubble on load-use hazards and holds EX for multi-cycle mul/div.
- Sits beside the ID/EX pipeline register, directly upstream of the forwarding muxes.

Parameters:
- MULDIV_LAT, 4, total EX residency in cycles of a mul/div op; legal range 1..15; 1 means no stall.
- REG_ADDR_W, 5, architectural register index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1, id_rs2  input  REG_ADDR_W  ID source registers.
- id_use_rs1, id_use_rs2  input  1  the source is actually read.
- ex_valid, ex_regwrite, ex_is_load, ex_muldiv  input  1  EX instruction attributes.
- ex_rd  input  REG_ADDR_W  EX destination.
- mem_valid, mem_regwrite  input  1  MEM instruction attributes.
- mem_rd  input  REG_ADDR_W  MEM destination.
- dmem_stall  input  1  data-memory handshake not complete; freezes the whole pipe.
- stall_if, stall_id  output  1  hold PC and IF/ID.
- stall_ex  output  1  hold ID/EX and the EX instruction.
- flush_ex  output  1  load ID/EX with a bubble.
- flush_mem  output  1  load EX/MEM with a bubble.
- fwd_rs1, fwd_rs2  output  forwarding_control (pipes package)  registered operand selects for the instruction in EX.

Behaviour:
- Reset (reset==0 at posedge):
  - state<=RUN, cnt<=0.
  - fwd_rs1/fwd_rs2<=FROM_ID_EX_ID.
  - All stall and flush outputs are 0 while reset is low.
  - Reset mid mul/div abandons the count immediately.
- Match definitions, for src in {rs1, rs2}:
  - hitE = ex_valid & ex_regwrite & ex_rd!=0 & id_use_src & id_rs_src==ex_rd.
  - hitM is the same with mem_*.
  - Register x0 never matches.
- Select computed in ID:
  - hitE (non-load) -> FROM_ALU_OUT.
  - else hitM -> FROM_WB.
  - else FROM_ID_EX_ID.
  - EX has priority over MEM (youngest producer wins).
  - The register file is write-through, so WB-stage producers need no select.
- Load-use: lu = id_valid & state==RUN & ex_is_load & (hitE_rs1 | hitE_rs2).
  - Drives stall_if=stall_id=flush_ex=1 for exactly one cycle.
  - The next cycle the load is in MEM, so hitM yields FROM_WB.
- FSM states: RUN, MD_BUSY.
  - RUN & ex_valid & ex_muldiv & MULDIV_LAT>1: stall_if=stall_id=stall_ex=flush_mem=1; cnt<=1; next MD_BUSY.
  - MD_BUSY with cnt<MULDIV_LAT-1: stalls and flush_mem asserted; cnt<=cnt+1.
  - MD_BUSY with cnt==MULDIV_LAT-1: no stall; next RUN.
  - EX residency is therefore MULDIV_LAT cycles, of which MULDIV_LAT-1 are stalled.
  - lu is suppressed while the mul/div stall is active.
- Select register update at posedge:
  - dmem_stall: hold fwd, state and cnt. All stall outputs read 1, flushes read 0.
  - else stall_ex: hold fwd.
  - else lu: fwd<=FROM_ID_EX_ID (the bubble).
  - else fwd<=computed select, or FROM_ID_EX_ID if !id_valid.
- Latency: the select is visible exactly one cycle after its instruction's last ID cycle.
- Simultaneous events:
  - dmem_stall overrides lu and FSM progress.
  - hitE and hitM on the same register resolve to FROM_ALU_OUT.
  - Both operands hitting a load still produce a single bubble.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- When defined:
  - Adds outputs lu_stall_cnt and md_stall_cnt, each 32 bits.
  - lu_stall_cnt counts cycles with lu=1 and !dmem_stall; md_stall_cnt counts stalled MD_BUSY/entry cycles with !dmem_stall.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- ALU producer to dependent: EX has rd=5 regwrite non-load; ID reads rs1=5 -> next cycle fwd_rs1=FROM_ALU_OUT, fwd_rs2=FROM_ID_EX_ID, no stall.
- Load-use: EX has a load with rd=7; ID reads rs2=7 -> one cycle of stall_if=stall_id=flush_ex=1. The cycle after, fwd_rs2 shows FROM_ID_EX_ID (bubble). Next cycle (MEM rd=7) yields fwd_rs2=FROM_WB with no stall.
- Priority and x0: EX rd=3 and MEM rd=3, ID rs1=3 -> FROM_ALU_OUT. With EX rd=0 and ID rs1=0 -> FROM_ID_EX_ID.
- Mul/div with MULDIV_LAT=4: ex_muldiv enters -> stall_ex=flush_mem=1 for 3 cycles, released on the 4th, FSM back to RUN. Under FWD_PERF_CNT_EN, md_stall_cnt=3.
- dmem_stall: asserted for 2 cycles during MD_BUSY at cnt=2 -> cnt and fwd frozen, flush_mem=0; release completes after 1 more stalled cycle.
- Reset: reset=0 during MD_BUSY -> next cycle state RUN, all stalls 0, fwd=FROM_ID_EX_ID.
